// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// registers the fetched {pc, inst} pair into the IF/ID boundary.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic        fetch_stall_o
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic [31:0] redirect_pc;
  logic [31:0] reset_pc_aligned;
  logic        unused_new_pc_low;

  // Redirect and reset targets are forced to word alignment.
  assign redirect_pc       = {new_pc_i[31:2], 2'b00};
  assign reset_pc_aligned  = {RESET_PC[31:2], 2'b00};
  assign unused_new_pc_low = &{1'b0, new_pc_i[1:0]};

  assign imem_req_o    = (state == S_FETCH);
  assign imem_addr_o   = pc;
  assign fetch_stall_o = (state == S_FETCH) && !imem_ack_i;

  // Fetch FSM: flush outranks ack, ack outranks stall; a stalled ack parks in the skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RESET;
      pc         <= reset_pc_aligned;
      skid_pc    <= 32'h0;
      skid_inst  <= NOP_INST;
      id_pc_o    <= 32'h0;
      id_inst_o  <= NOP_INST;
      id_valid_o <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state <= S_FETCH;
        end

        S_FETCH: begin
          if (flush_i) begin
            pc         <= redirect_pc;
            id_pc_o    <= 32'h0;
            id_inst_o  <= NOP_INST;
            id_valid_o <= 1'b0;
          end else if (imem_ack_i && !stall_i) begin
            id_pc_o    <= pc;
            id_inst_o  <= imem_rdata_i;
            id_valid_o <= 1'b1;
            pc         <= pc + 32'd4;
          end else if (imem_ack_i) begin
            skid_pc   <= pc;
            skid_inst <= imem_rdata_i;
            pc        <= pc + 32'd4;
            state     <= S_HOLD;
          end else if (!stall_i) begin
            id_inst_o  <= NOP_INST;
            id_valid_o <= 1'b0;
          end
        end

        S_HOLD: begin
          if (flush_i) begin
            pc         <= redirect_pc;
            id_pc_o    <= 32'h0;
            id_inst_o  <= NOP_INST;
            id_valid_o <= 1'b0;
            state      <= S_FETCH;
          end else if (!stall_i) begin
            id_pc_o    <= skid_pc;
            id_inst_o  <= skid_inst;
            id_valid_o <= 1'b1;
            state      <= S_FETCH;
          end
        end

        default: begin
          state <= S_RESET;
        end
      endcase
    end
  end

endmodule
